ddr3_read_stream_buffer: RTL and testbench
==========================================

DDR3_READ_STREAM_BUFFER -- requirements
Module: ddr3_read_stream_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256, width of a beat.
REQ-002 SHALL have parameter DEPTH, default 64, FIFO entries; power of 2, at least 4.
REQ-003 SHALL have parameter AF_MARGIN, default 16, free-entry threshold for almost_full.
REQ-004 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  in  1  one-cycle pulse that arms a transfer.
REQ-007 SHALL have port exp_beats  in  32  number of beats expected, sampled on accepted start.
REQ-008 SHALL have port in_vld  in  1  upstream beat valid; there is no backpressure.
REQ-009 SHALL have port in_dat  in  DATA_WIDTH  upstream beat data.
REQ-010 SHALL have port out_vld  out  1  head entry valid.
REQ-011 SHALL have port out_dat  out  DATA_WIDTH  head entry data.
REQ-012 SHALL have port out_rdy  in  1  consumer ready.
REQ-013 SHALL have port level  out  clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port almost_full  out  1  high when level >= DEPTH-AF_MARGIN.
REQ-015 SHALL have port busy  out  1  high in RECV or DRAIN.
REQ-016 SHALL have port done  out  1  one-cycle completion pulse.
REQ-017 SHALL have port overflow  out  1  sticky flag for a dropped beat.

Function
REQ-018 SHALL write in_dat into the FIFO every cycle in_vld=1, in any state, unless the FIFO is full with no same-cycle pop.
- If the FIFO is full with no same-cycle pop, the beat is dropped and overflow is set.
REQ-019 SHALL pop the head on out_vld&out_rdy; out_dat stays stable while out_vld=1 and out_rdy=0.
REQ-020 SHALL be first-word-fall-through: a beat written in cycle N appears on out_vld/out_dat at N+1, with no same-cycle bypass.
REQ-021 SHALL accept the write when push and pop coincide at full; level is then unchanged and nothing is dropped.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH.
- level = writes minus pops, saturating at neither end because overflow and underflow are prevented.
REQ-023 SHALL implement an FSM with states IDLE, RECV and DRAIN.
REQ-024 IDLE: an accepted start clears overflow, latches exp_beats and zeroes beat_cnt (32-bit).
- Next state is RECV, or DRAIN if exp_beats=0.
REQ-025 RECV: beat_cnt increments on every in_vld, whether stored or dropped.
- When beat_cnt+1 equals the latched value on an in_vld cycle, the next state is DRAIN.
REQ-026 DRAIN: when level=0 (out_vld=0), assert done for exactly one cycle and return to IDLE.
REQ-027 SHALL ignore start while busy=1; the latched count and beat_cnt are unaffected.
REQ-028 SHALL store beats arriving in IDLE or DRAIN but not count them.

Reset
REQ-029 On rst_n=0, the block SHALL immediately clear the FSM to IDLE and clear the pointers, level, beat_cnt, the latched count, out_vld, almost_full, busy, done, overflow and drop_cnt.
- FIFO storage contents are not reset.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered beats; no done pulse follows.

Configuration
REQ-031 With macro DDR3_RDBUF_DROP_CNT_EN defined, the block SHALL add output drop_cnt (16 bits).
- drop_cnt increments per dropped beat, saturates at 16'hFFFF, and clears on accepted start.
REQ-032 Without DDR3_RDBUF_DROP_CNT_EN, the drop_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Start with exp_beats=8, 8 consecutive in_vld, out_rdy=1 -> 8 beats out in order, first out_vld one cycle after the first in_vld, done one cycle after the FIFO empties, overflow=0.
REQ-034 DEPTH=64, out_rdy=0, exp_beats=70, 70 beats -> level=64, overflow=1, drop_cnt=6 (macro on), almost_full high from level 48.
- Then set out_rdy=1 -> 64 beats out, then done.
REQ-035 Fill to full, then one cycle with in_vld=1 and out_rdy=1 -> level stays 64, no drop, overflow=0.
REQ-036 Start with exp_beats=0 -> done on the second cycle after start, busy high for exactly one cycle.
REQ-037 Second start during RECV -> ignored; done fires only after the original count.
REQ-038 Deassert rst_n while level=10 in RECV -> out_vld=0, level=0, busy=0 at once; no done pulse.

Source files
------------

// File: rtl/ddr3_read_stream_buffer.sv
// DDR3 read-return stream buffer: FWFT FIFO plus beat-count tracking FSM.
// Define DDR3_RDBUF_DROP_CNT_EN to add the saturating drop_cnt output.
module ddr3_read_stream_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int DEPTH      = 64,
  parameter int AF_MARGIN  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [31:0]                 exp_beats,
  input  logic                        in_vld,
  input  logic [DATA_WIDTH-1:0]       in_dat,
  output logic                        out_vld,
  output logic [DATA_WIDTH-1:0]       out_dat,
  input  logic                        out_rdy,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        almost_full,
  output logic                        busy,
  output logic                        done,
`ifdef DDR3_RDBUF_DROP_CNT_EN
  output logic [15:0]                 drop_cnt,
`endif
  output logic                        overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL   = LW'(DEPTH);
  localparam logic [LW-1:0] AF_LVL = LW'(DEPTH - AF_MARGIN);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DRAIN
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   exp_lat;
  logic [31:0]   beat_cnt;

  logic full;
  logic pop;
  logic push;
  logic drop;
  logic start_acc;

  assign full      = (level == FULL);
  assign pop       = out_vld & out_rdy;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts
  assign push      = in_vld & (~full | pop);
  assign drop      = in_vld & full & ~pop;
  assign start_acc = start & (state == IDLE);

  assign out_vld     = (level != '0);
  assign out_dat     = mem[rd_ptr];
  assign almost_full = (level >= AF_LVL);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      exp_lat  <= '0;
      beat_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done     <= 1'b0;
      overflow <= (overflow & ~start_acc) | drop;
      unique case (state)
        IDLE: begin
          if (start) begin
            exp_lat  <= exp_beats;
            beat_cnt <= '0;
            state    <= (exp_beats == '0) ? DRAIN : RECV;
          end
        end
        RECV: begin
          if (in_vld) begin
            beat_cnt <= beat_cnt + 32'd1;
            if (beat_cnt + 32'd1 == exp_lat) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!out_vld) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR3_RDBUF_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (start_acc) begin
      drop_cnt <= {15'd0, drop};
    end else if (drop && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ddr3_read_stream_buffer.sv
// Bench for ddr3_read_stream_buffer: queue model checked every cycle
// plus directed scenarios with literal expectations.
module tb_ddr3_read_stream_buffer;

  localparam int DW    = 256;
  localparam int DEPTH = 64;
  localparam int AFM   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   exp_beats = '0;
  logic          in_vld = 1'b0;
  logic [DW-1:0] in_dat = '0;
  logic          out_vld;
  logic [DW-1:0] out_dat;
  logic          out_rdy = 1'b0;
  logic [6:0]    level;
  logic          almost_full;
  logic          busy;
  logic          done;
  logic          overflow;
`ifdef DDR3_RDBUF_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int seq = 0;

  ddr3_read_stream_buffer #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AF_MARGIN(AFM)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .exp_beats(exp_beats),
    .in_vld(in_vld),
    .in_dat(in_dat),
    .out_vld(out_vld),
    .out_dat(out_dat),
    .out_rdy(out_rdy),
    .level(level),
    .almost_full(almost_full),
    .busy(busy),
    .done(done),
`ifdef DDR3_RDBUF_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue and a transfer descriptor
  logic [DW-1:0] mq[$];
  bit            m_busy = 0;
  bit            m_recv = 0;
  bit            m_done = 0;
  bit            m_ovf = 0;
  int unsigned   m_target = 0;
  int unsigned   m_seen = 0;
  int            m_drops = 0;
  int            m_sz;
  bit            m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_busy = 0;
      m_recv = 0;
      m_done = 0;
      m_ovf = 0;
      m_target = 0;
      m_seen = 0;
      m_drops = 0;
    end else begin
      m_sz = mq.size();
      m_pop = (m_sz > 0) && out_rdy;
      m_done = 0;
      if (!m_busy && start) begin
        m_ovf = 0;
        m_drops = 0;
      end
      if (m_pop) void'(mq.pop_front());
      if (in_vld) begin
        if (m_sz < DEPTH || m_pop) mq.push_back(in_dat);
        else begin
          m_ovf = 1;
          if (m_drops < 65535) m_drops++;
        end
      end
      if (!m_busy) begin
        if (start) begin
          m_target = exp_beats;
          m_seen = 0;
          m_busy = 1;
          m_recv = (exp_beats != 0);
        end
      end else if (m_recv) begin
        if (in_vld) begin
          m_seen++;
          if (m_seen == m_target) m_recv = 0;
        end
      end else if (m_sz == 0) begin
        m_done = 1;
        m_busy = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_out_vld", out_vld, mq.size() != 0);
    chk("m_level", level, mq.size());
    if (mq.size() != 0) chk("m_out_dat", out_dat, mq[0]);
    chk("m_almost_full", almost_full, mq.size() >= DEPTH - AFM);
    chk("m_busy", busy, m_busy);
    chk("m_done", done, m_done);
    chk("m_overflow", overflow, m_ovf);
`ifdef DDR3_RDBUF_DROP_CNT_EN
    chk("m_drop_cnt", drop_cnt, m_drops);
`endif
  end

  function automatic logic [DW-1:0] pat(input int k);
    logic [31:0] w;
    w = (32'(k) * 32'h9E3779B1) ^ 32'hC0DE0000;
    return {8{w}};
  endfunction

  task automatic cyc(input logic s, input logic [31:0] e,
                     input logic v, input logic r);
    start = s;
    exp_beats = e;
    in_vld = v;
    out_rdy = r;
    if (v) begin
      in_dat = pat(seq);
      seq++;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    in_vld = 1'b0;
  endtask

  task automatic wait_done(input logic r, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      cyc(1'b0, 32'd0, 1'b0, r);
      n++;
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  int n;
  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_af", almost_full, 0);
    rst_n = 1'b1;
    cyc(1'b0, 32'd0, 1'b0, 1'b1);

    // Eight beats streamed straight through
    cyc(1'b1, 32'd8, 1'b0, 1'b1);
    base = seq;
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    chk("t1_first_vld", out_vld, 1);
    chk("t1_first_dat", out_dat, pat(base));
    for (int i = 1; i < 8; i++) cyc(1'b0, 32'd0, 1'b1, 1'b1);
    wait_done(1'b1, 20, n);
    chk("t1_done_lat", n, 2);
    chk("t1_overflow", overflow, 0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);

    // Seventy beats into a stalled 64-entry FIFO
    cyc(1'b1, 32'd70, 1'b0, 1'b0);
    for (int i = 1; i <= 70; i++) begin
      cyc(1'b0, 32'd0, 1'b1, 1'b0);
      if (i == 47) chk("t2_af_47", almost_full, 0);
      if (i == 48) chk("t2_af_48", almost_full, 1);
    end
    chk("t2_level", level, 64);
    chk("t2_overflow", overflow, 1);
`ifdef DDR3_RDBUF_DROP_CNT_EN
    chk("t2_drop_cnt", drop_cnt, 6);
`endif
    wait_done(1'b1, 100, n);
    chk("t2_drain_len", n, 65);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);

    // Push and pop together while full
    cyc(1'b1, 32'd64, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("t3_full", level, 64);
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    chk("t3_level", level, 64);
    chk("t3_overflow", overflow, 0);
    wait_done(1'b1, 100, n);
    chk("t3_drain_len", n, 65);

    // Zero-length transfer
    cyc(1'b1, 32'd0, 1'b0, 1'b1);
    chk("t4_busy1", busy, 1);
    chk("t4_done1", done, 0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("t4_busy2", busy, 0);
    chk("t4_done2", done, 1);
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
    chk("t4_done3", done, 0);

    // Restart attempt while receiving is ignored
    cyc(1'b1, 32'd4, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    cyc(1'b1, 32'd100, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b1, 1'b1);
    wait_done(1'b1, 10, n);
    chk("t5_done_lat", n, 2);

    // Asynchronous reset with ten beats buffered
    cyc(1'b1, 32'd20, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("t6_level_pre", level, 10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_out_vld", out_vld, 0);
    chk("t6_level", level, 0);
    chk("t6_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 32'd0, 1'b0, 1'b1);
      chk("t6_no_done", done, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
